// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: filters and deserialises mouse frames, assembles
// 3-byte stream packets and accumulates a cursor clamped to 640x480.
// Ports: clk_100MHz, reset_n (async low), ps2_clk/ps2_data (async in),
//   xm/ym cursor, btn_l/btn_r/btn_m, pkt_valid and err 1-cycle pulses.
// Define PS2_ACCEL_EN to double per-axis deltas larger than ACCEL_THR.
module ps2_mouse_tracker #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 25000,
  parameter int H_MAX       = 639,
  parameter int V_MAX       = 479,
  parameter int X_RESET     = 320,
  parameter int Y_RESET     = 240,
  parameter int ACCEL_THR   = 16
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] xm,
  output logic [9:0] ym,
  output logic       btn_l,
  output logic       btn_r,
  output logic       btn_m,
  output logic       pkt_valid,
  output logic       err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic signed [11:0] HMAX = 12'(H_MAX);
  localparam logic signed [11:0] VMAX = 12'(V_MAX);

  typedef enum logic [1:0] {
    F_IDLE,
    F_SHIFT,
    F_CHECK
  } fstate_t;

  typedef enum logic [1:0] {
    P_B0,
    P_B1,
    P_B2
  } pstate_t;

  // synchronisers idle high like the bus
  logic c_s1_q, c_s2_q, d_s1_q, d_s2_q;

  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          clk_f_q, clk_f_d;
  logic          fall;

  fstate_t       fst_q, fst_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_rdy, frame_err;

  pstate_t       pst_q, pst_d;
  // b0 kept without the always-one bit:
  // {yovf,xovf,ysign,xsign,mid,right,left}
  logic [6:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic [7:0]    b2_q, b2_d;
  logic          go_q, go_d;

  logic [9:0]    xm_q, xm_d, ym_q, ym_d;
  logic [2:0]    btn_q, btn_d;
  logic          pv_q, pv_d, err_q, err_d;

  logic signed [11:0] dx, dy, nx, ny;

  function automatic logic signed [11:0] accel(
    input logic signed [11:0] d
  );
`ifdef PS2_ACCEL_EN
    logic signed [11:0] thr;
    thr = 12'(ACCEL_THR);
    if (d > thr || d < -thr) return d <<< 1;
    return d;
`else
    return d;
`endif
  endfunction

  function automatic logic [9:0] clamp(
    input logic signed [11:0] v,
    input logic signed [11:0] mx
  );
    if (v < 0) return '0;
    if (v > mx) return mx[9:0];
    return v[9:0];
  endfunction

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      c_s1_q <= 1'b1;
      c_s2_q <= 1'b1;
      d_s1_q <= 1'b1;
      d_s2_q <= 1'b1;
    end else begin
      c_s1_q <= ps2_clk;
      c_s2_q <= c_s1_q;
      d_s1_q <= ps2_data;
      d_s2_q <= d_s1_q;
    end
  end

  // level flips only after FILTER_LEN consecutive differing samples
  always_comb begin
    flt_cnt_d = '0;
    clk_f_d   = clk_f_q;
    fall      = 1'b0;
    if (c_s2_q != clk_f_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_f_d = c_s2_q;
        fall    = clk_f_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
  end

  // shreg fills LSB first: [7:0] data, [8] parity, [9] stop
  always_comb begin
    fst_d     = fst_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tmo_d     = '0;
    byte_rdy  = 1'b0;
    frame_err = 1'b0;
    unique case (fst_q)
      F_IDLE: begin
        if (fall && !d_s2_q) begin
          fst_d     = F_SHIFT;
          bit_cnt_d = '0;
        end
      end
      F_SHIFT: begin
        if (fall) begin
          shreg_d   = {d_s2_q, shreg_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) fst_d = F_CHECK;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          frame_err = 1'b1;
          fst_d     = F_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      F_CHECK: begin
        fst_d = F_IDLE;
        if ((^shreg_q[8:0]) && shreg_q[9]) byte_rdy = 1'b1;
        else frame_err = 1'b1;
      end
      default: fst_d = F_IDLE;
    endcase
  end

  always_comb begin
    pst_d = pst_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    b2_d  = b2_q;
    go_d  = 1'b0;
    if (frame_err) begin
      pst_d = P_B0;
    end else if (byte_rdy) begin
      unique case (pst_q)
        P_B0: begin
          // bit3 clear means we are out of step: drop it
          if (shreg_q[3]) begin
            b0_d  = {shreg_q[7:4], shreg_q[2:0]};
            pst_d = P_B1;
          end
        end
        P_B1: begin
          b1_d  = shreg_q[7:0];
          pst_d = P_B2;
        end
        P_B2: begin
          b2_d  = shreg_q[7:0];
          go_d  = 1'b1;
          pst_d = P_B0;
        end
        default: pst_d = P_B0;
      endcase
    end
  end

  always_comb begin
    dx = b0_q[5] ? 12'sd0 : accel({{3{b0_q[3]}}, b0_q[3], b1_q});
    dy = b0_q[6] ? 12'sd0 : accel({{3{b0_q[4]}}, b0_q[4], b2_q});
    nx = $signed({2'b00, xm_q}) + dx;
    // PS/2 reports y up-positive, screen y grows downwards
    ny = $signed({2'b00, ym_q}) - dy;
    xm_d  = xm_q;
    ym_d  = ym_q;
    btn_d = btn_q;
    pv_d  = go_q;
    err_d = frame_err;
    if (go_q) begin
      xm_d  = clamp(nx, HMAX);
      ym_d  = clamp(ny, VMAX);
      btn_d = b0_q[2:0];
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt_q <= '0;
      clk_f_q   <= 1'b1;
      fst_q     <= F_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tmo_q     <= '0;
      pst_q     <= P_B0;
      b0_q      <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      go_q      <= 1'b0;
      xm_q      <= 10'(X_RESET);
      ym_q      <= 10'(Y_RESET);
      btn_q     <= '0;
      pv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      flt_cnt_q <= flt_cnt_d;
      clk_f_q   <= clk_f_d;
      fst_q     <= fst_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tmo_q     <= tmo_d;
      pst_q     <= pst_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      go_q      <= go_d;
      xm_q      <= xm_d;
      ym_q      <= ym_d;
      btn_q     <= btn_d;
      pv_q      <= pv_d;
      err_q     <= err_d;
    end
  end

  assign xm        = xm_q;
  assign ym        = ym_q;
  assign btn_l     = btn_q[0];
  assign btn_r     = btn_q[1];
  assign btn_m     = btn_q[2];
  assign pkt_valid = pv_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: drives PS/2 frames and checks the
// cursor against a packet-level model every cycle.
module tb_ps2_mouse_tracker;

  localparam int HALF = 12;
  localparam int GAP  = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pclk = 1'b1;
  logic       pdat = 1'b1;
  logic [9:0] xm, ym;
  logic       btn_l, btn_r, btn_m, pkt_valid, err;

  always #5 clk = ~clk;

  ps2_mouse_tracker dut (
    .clk_100MHz(clk),
    .reset_n   (rst_n),
    .ps2_clk   (pclk),
    .ps2_data  (pdat),
    .xm        (xm),
    .ym        (ym),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .btn_m     (btn_m),
    .pkt_valid (pkt_valid),
    .err       (err)
  );

  typedef struct {
    int x;
    int y;
    int b;
  } res_t;

  int checks = 0;
  int passed = 0;
  int pred_x = 320, pred_y = 240;
  int cur_x = 320, cur_y = 240, cur_b = 0;
  int err_exp = 0;
  int pv_cnt = 0, err_cnt = 0;
  logic [7:0] pend[$];
  res_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int acc(input int d);
`ifdef PS2_ACCEL_EN
    if (d > 16 || d < -16) return 2 * d;
`endif
    return d;
  endfunction

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit ok);
    int dx, dy;
    res_t r;
    if (!ok) begin
      err_exp++;
      pend.delete();
      return;
    end
    if (pend.size() == 0 && !b[3]) return;
    pend.push_back(b);
    if (pend.size() == 3) begin
      dx = int'(pend[1]) - (pend[0][4] ? 256 : 0);
      dy = int'(pend[2]) - (pend[0][5] ? 256 : 0);
      if (pend[0][6]) dx = 0;
      if (pend[0][7]) dy = 0;
      pred_x = clampi(pred_x + acc(dx), 639);
      pred_y = clampi(pred_y - acc(dy), 479);
      r.x = pred_x;
      r.y = pred_y;
      r.b = int'(pend[0][2:0]);
      exp_q.push_back(r);
      pend.delete();
    end
  endtask

  task automatic ps2_bit(input logic v);
    pdat = v;
    repeat (HALF) @(posedge clk);
    #1 pclk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 pclk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    logic par;
    model_byte(b, !bad);
    par = (~^b) ^ bad;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    pdat = 1'b1;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c);
    send_byte(a, 1'b0);
    send_byte(b, 1'b0);
    send_byte(c, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    pend.delete();
    exp_q.delete();
    err_exp = 0;
    pred_x = 320;
    pred_y = 240;
    cur_x = 320;
    cur_y = 240;
    cur_b = 0;
    pclk = 1'b1;
    pdat = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_xm", int'(xm), 320);
      chk("rst_ym", int'(ym), 240);
      chk("rst_btn", int'({btn_m, btn_r, btn_l}), 0);
      chk("rst_pulses", int'({pkt_valid, err}), 0);
    end else begin
      chk("pv_err_excl", int'(pkt_valid && err), 0);
      if (pkt_valid) begin
        pv_cnt++;
        chk("pv_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur_x = exp_q[0].x;
          cur_y = exp_q[0].y;
          cur_b = exp_q[0].b;
          void'(exp_q.pop_front());
        end
      end
      if (err) begin
        err_cnt++;
        chk("err_expected", int'(err_exp > 0), 1);
        if (err_exp > 0) err_exp--;
      end
      chk("xm", int'(xm), cur_x);
      chk("ym", int'(ym), cur_y);
      chk("btn", int'({btn_m, btn_r, btn_l}), cur_b);
    end
  end

  int pv0, er0;

  initial begin
    do_reset();
    chk("t0_xm", int'(xm), 320);
    chk("t0_ym", int'(ym), 240);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    do_reset();
    chk("t1_xm", int'(xm), 320);
    chk("t1_ym", int'(ym), 240);
    pv0 = pv_cnt;
    pkt(8'h08, 8'h0A, 8'h05);
    chk("t2_xm", int'(xm), 330);
    chk("t2_ym", int'(ym), 235);
    chk("t2_pv_once", pv_cnt - pv0, 1);
    chk("model_x", cur_x, 330);
    pkt(8'h09, 8'h00, 8'h00);
    chk("t2_btn_l", int'(btn_l), 1);
    chk("t2_xm_hold", int'(xm), 330);

    pkt(8'h08, 8'hFF, 8'h00);
    pkt(8'h08, 8'hFF, 8'h00);
    pkt(8'h18, 8'hF7, 8'h00);
    chk("t3_630", int'(xm), 630);
    pkt(8'h08, 8'h14, 8'h00);
    chk("t3_xmax", int'(xm), 639);
    pkt(8'h18, 8'h01, 8'h00);
    pkt(8'h18, 8'h01, 8'h00);
    pkt(8'h18, 8'h01, 8'h00);
    pkt(8'h08, 8'h0A, 8'h00);
    chk("t3_10", int'(xm), 10);
    pkt(8'h18, 8'hEC, 8'h00);
    chk("t3_xmin", int'(xm), 0);
    pkt(8'h08, 8'h00, 8'hFF);
    chk("t3_ymin", int'(ym), 0);
    pkt(8'h28, 8'h00, 8'hFB);
    chk("t3_5", int'(ym), 5);
    pkt(8'h28, 8'h00, 8'hF6);
    chk("t3_15", int'(ym), 15);
    pkt(8'h28, 8'h00, 8'h01);
    pkt(8'h28, 8'h00, 8'h01);
    pkt(8'h08, 8'h00, 8'h04);
    chk("t3_475", int'(ym), 475);
    pkt(8'h28, 8'h00, 8'hF6);
    chk("t3_ymax", int'(ym), 479);
    pkt(8'h48, 8'h50, 8'h05);
    chk("t3_xovf_x", int'(xm), 0);
    chk("t3_xovf_y", int'(ym), 474);

    pv0 = pv_cnt;
    er0 = err_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h0A, 1'b1);
    chk("t4_err", err_cnt - er0, 1);
    chk("t4_no_pv", pv_cnt - pv0, 0);
    pkt(8'h08, 8'h0A, 8'h05);
    chk("t4_xm", int'(xm), 10);
    chk("t4_ym", int'(ym), 469);

    pv0 = pv_cnt;
    send_byte(8'h00, 1'b0);
    pkt(8'h08, 8'h0A, 8'h05);
    chk("t5_pv_once", pv_cnt - pv0, 1);
    chk("t5_xm", int'(xm), 20);
    er0 = err_cnt;
    err_exp++;
    pend.delete();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    pdat = 1'b1;
    repeat (30000) @(posedge clk);
    chk("t5_tmo_err", err_cnt - er0, 1);
    pkt(8'h09, 8'h0A, 8'h05);
    chk("t5_xm2", int'(xm), 30);
    chk("t5_ym2", int'(ym), 459);
    chk("t5_btn", int'(btn_l), 1);

    do_reset();
    pkt(8'h08, 8'h20, 8'h00);
`ifdef PS2_ACCEL_EN
    chk("t6_accel", int'(xm), 384);
    pkt(8'h08, 8'h0A, 8'h00);
    chk("t6_small", int'(xm), 394);
`else
    chk("t6_accel", int'(xm), 352);
    pkt(8'h08, 8'h0A, 8'h00);
    chk("t6_small", int'(xm), 362);
`endif

    repeat (50) @(posedge clk);
    chk("exp_drained", exp_q.size(), 0);
    chk("err_drained", err_exp, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
